// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and bit-timing helper
package uart_pkg;

    // Receiver FSM states; PARITY is only reachable when the parity build option is on
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_t;

    // Clocks per line bit; shared with uart_tx so both ends agree on the bit period
    function automatic int unsigned calc_pulse_width(input int unsigned clk_freq,
                                                     input int unsigned baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchroniser, resets to all ones (idle line level)
module uart_rx_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two-stage capture; reset to 1 so a reset never looks like a start bit
    always_ff @(posedge clk) begin
        if (!rstn) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with valid/ready output; optional even parity via UART_RX_PARITY_EN
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BAUD_RATE  = 9600,
    parameter int CLK_FREQ   = 100_000_000
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  rx_sig,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  valid,
    input  logic                  ready,
    output logic                  frame_err,
    output logic                  parity_err,
    output logic                  overrun
);

    localparam int PULSE_WIDTH      = calc_pulse_width(CLK_FREQ, BAUD_RATE);
    localparam int HALF_PULSE_WIDTH = PULSE_WIDTH / 2;
    localparam int CW               = $clog2(PULSE_WIDTH) + 1;
    localparam int BW               = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CW-1:0] CNT_FULL = CW'(PULSE_WIDTH - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF_PULSE_WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);
    localparam logic [BW-1:0] BIT_ONE  = BW'(1);

    logic                  rx_s;
    rx_state_t             state;
    rx_state_t             state_nxt;
    logic [CW-1:0]         clk_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shift;
    logic                  cnt_zero;
    logic                  last_bit;
    logic                  commit;
    logic                  out_free;

    // All line decisions are taken on the synchronised copy only
    uart_rx_sync #(
        .WIDTH(1)
    ) u_sync (
        .clk (clk),
        .rstn(rstn),
        .d   (rx_sig),
        .q   (rx_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: every timed state advances only on its mid-bit sample
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!rx_s) state_nxt = START;
            end
            START: begin
                if (cnt_zero) state_nxt = rx_s ? IDLE : DATA;
            end
            DATA: begin
                if (cnt_zero && last_bit) begin
`ifdef UART_RX_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_zero) state_nxt = STOP;
            end
`endif
            STOP: begin
                if (cnt_zero) state_nxt = rx_s ? IDLE : BREAK;
            end
            BREAK: begin
                if (rx_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Decoded strobes: mid-bit sample, last data bit, word commit, output slot free
    always_comb begin
        cnt_zero = (clk_cnt == '0);
        last_bit = (bit_cnt == BIT_LAST);
        commit   = (state == STOP) && cnt_zero;
        out_free = !valid || ready;
    end

    // Bit timer, bit index and shift register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            clk_cnt <= '0;
            bit_cnt <= '0;
            shift   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Half a bit to reach the middle of the start bit
                    if (!rx_s) clk_cnt <= CNT_HALF;
                end
                START, DATA, PARITY, STOP: begin
                    clk_cnt <= cnt_zero ? CNT_FULL : (clk_cnt - CNT_ONE);
                end
                default: clk_cnt <= clk_cnt;
            endcase
            if ((state == START) && cnt_zero) begin
                bit_cnt <= '0;
            end
            if ((state == DATA) && cnt_zero) begin
                shift[bit_cnt] <= rx_s;
                bit_cnt        <= bit_cnt + BIT_ONE;
            end
        end
    end

    // Output word register: commit into a free slot, otherwise flag the dropped word
    always_ff @(posedge clk) begin
        if (!rstn) begin
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            overrun <= commit && !out_free;
            if (commit && out_free) begin
                data      <= shift;
                valid     <= 1'b1;
                frame_err <= ~rx_s;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bit;

    // Captures the received parity bit at its mid-point
    always_ff @(posedge clk) begin
        if (!rstn) begin
            par_bit <= 1'b0;
        end else if ((state == PARITY) && cnt_zero) begin
            par_bit <= rx_s;
        end
    end

    // Even parity: data plus parity bit must have an even number of ones
    always_ff @(posedge clk) begin
        if (!rstn) begin
            parity_err <= 1'b0;
        end else if (commit && out_free) begin
            parity_err <= ^{shift, par_bit};
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx at 10 clocks per bit
module tb_uart_rx;
    import uart_pkg::*;

    localparam int PW = 10;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       rx_sig = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;

    always #5 clk = ~clk;

    uart_rx #(
        .DATA_WIDTH(8),
        .BAUD_RATE (100_000),
        .CLK_FREQ  (1_000_000)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .rx_sig    (rx_sig),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .overrun   (overrun)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   hs_cnt = 0;
    int   ovr_cnt = 0;
    int   vcyc = 0;
`ifdef UART_RX_PARITY_EN
    logic par_flip = 1'b0;
`endif

    // One clock step; a handshake due at the coming edge pops the scoreboard
    task automatic tick();
        exp_t e;
        if (valid === 1'b1 && ready === 1'b1) begin
            hs_cnt++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got data=%h fe=%b pe=%b, required no word", data, frame_err, parity_err);
            end else begin
                e = exp_q.pop_front();
                if ({data, frame_err, parity_err} !== e) begin
                    bad++;
                    $display("FAIL sb_word: got data=%h fe=%b pe=%b, required data=%h fe=%b pe=%b",
                             data, frame_err, parity_err, e.d, e.fe, e.pe);
                end
            end
        end
        @(posedge clk);
        #1;
        if (overrun === 1'b1) ovr_cnt++;
        if (valid === 1'b1) vcyc++;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic send_bit(input logic b);
        rx_sig = b;
        ticks(PW);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ par_flip);
`endif
        send_bit(stop_bit);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        rx_sig = 1'b1;
        ticks(3);
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b, required 0", valid); end
        total++; if (data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h, required 00", data); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_fe: got %b, required 0", frame_err); end
        total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL reset_pe: got %b, required 0", parity_err); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_ovr: got %b, required 0", overrun); end
        total++; if (dut.state !== IDLE) begin bad++; $display("FAIL reset_state: got %0d, required %0d", dut.state, IDLE); end
        rstn = 1'b1;
        ticks(3);
    endtask

    task automatic test_basic();
        int hs0, v0, o0;
        ready = 1'b1;
        hs0 = hs_cnt; v0 = vcyc; o0 = ovr_cnt;
        exp_q.push_back({8'hA5, 1'b0, 1'b0});
        send_frame(8'hA5, 1'b1);
        ticks(20);
        total++; if (hs_cnt - hs0 != 1) begin bad++; $display("FAIL basic_hs: got %0d, required 1", hs_cnt - hs0); end
        total++; if (vcyc - v0 != 1) begin bad++; $display("FAIL basic_valid_cycles: got %0d, required 1", vcyc - v0); end
        total++; if (ovr_cnt != o0) begin bad++; $display("FAIL basic_ovr: got %0d, required 0", ovr_cnt - o0); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL basic_valid_drop: got %b, required 0", valid); end
    endtask

    task automatic test_glitch();
        int hs0, v0;
        ready = 1'b1;
        hs0 = hs_cnt; v0 = vcyc;
        rx_sig = 1'b0;
        ticks(3);
        rx_sig = 1'b1;
        ticks(3);
        total++; if (dut.state !== START) begin bad++; $display("FAIL glitch_start: got %0d, required %0d", dut.state, START); end
        ticks(30);
        total++; if (dut.state !== IDLE) begin bad++; $display("FAIL glitch_idle: got %0d, required %0d", dut.state, IDLE); end
        total++; if (vcyc != v0 || hs_cnt != hs0) begin bad++; $display("FAIL glitch_valid: got %0d valid cycles, required 0", vcyc - v0); end
    endtask

    task automatic test_frame_err();
        int hs0;
        ready = 1'b1;
        hs0 = hs_cnt;
        exp_q.push_back({8'h3C, 1'b1, 1'b0});
        send_frame(8'h3C, 1'b0);
        ticks(30);
        total++; if (dut.state !== BREAK) begin bad++; $display("FAIL break_hold: got %0d, required %0d", dut.state, BREAK); end
        total++; if (hs_cnt - hs0 != 1) begin bad++; $display("FAIL break_hs: got %0d, required 1", hs_cnt - hs0); end
        rx_sig = 1'b1;
        ticks(5);
        total++; if (dut.state !== IDLE) begin bad++; $display("FAIL break_exit: got %0d, required %0d", dut.state, IDLE); end
        exp_q.push_back({8'h3C, 1'b0, 1'b0});
        send_frame(8'h3C, 1'b1);
        ticks(20);
        total++; if (hs_cnt - hs0 != 2) begin bad++; $display("FAIL break_next_hs: got %0d, required 2", hs_cnt - hs0); end
    endtask

    task automatic test_overrun();
        int hs0, o0;
        ready = 1'b0;
        hs0 = hs_cnt; o0 = ovr_cnt;
        exp_q.push_back({8'h11, 1'b0, 1'b0});
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        ticks(10);
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL ovr_valid: got %b, required 1", valid); end
        total++; if (data !== 8'h11) begin bad++; $display("FAIL ovr_data_hold: got %h, required 11", data); end
        total++; if (ovr_cnt - o0 != 1) begin bad++; $display("FAIL ovr_pulse: got %0d, required 1", ovr_cnt - o0); end
        total++; if (hs_cnt != hs0) begin bad++; $display("FAIL ovr_no_hs: got %0d, required 0", hs_cnt - hs0); end
        ready = 1'b1;
        ticks(5);
        total++; if (hs_cnt - hs0 != 1) begin bad++; $display("FAIL ovr_one_hs: got %0d, required 1", hs_cnt - hs0); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL ovr_drop: got %b, required 0", valid); end
    endtask

    task automatic test_parity();
        int hs0;
        ready = 1'b1;
        hs0 = hs_cnt;
`ifdef UART_RX_PARITY_EN
        par_flip = 1'b0;
        exp_q.push_back({8'h07, 1'b0, 1'b0});
        send_frame(8'h07, 1'b1);
        par_flip = 1'b1;
        exp_q.push_back({8'h07, 1'b0, 1'b1});
        send_frame(8'h07, 1'b1);
        par_flip = 1'b0;
        ticks(20);
        total++; if (hs_cnt - hs0 != 2) begin bad++; $display("FAIL parity_hs: got %0d, required 2", hs_cnt - hs0); end
`else
        exp_q.push_back({8'h07, 1'b0, 1'b0});
        send_frame(8'h07, 1'b1);
        ticks(20);
        total++; if (hs_cnt - hs0 != 1) begin bad++; $display("FAIL parity_hs: got %0d, required 1", hs_cnt - hs0); end
`endif
    endtask

    task automatic test_reset_mid();
        int hs0;
        logic [7:0] d;
        ready = 1'b0;
        send_frame(8'h77, 1'b1);
        ticks(5);
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL rmid_pending: got %b, required 1", valid); end
        d = 8'h5A;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        rx_sig = d[4];
        ticks(5);
        rstn = 1'b0;
        rx_sig = 1'b1;
        tick();
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL rmid_valid: got %b, required 0", valid); end
        total++; if (dut.state !== IDLE) begin bad++; $display("FAIL rmid_state: got %0d, required %0d", dut.state, IDLE); end
        total++; if (data !== 8'h00) begin bad++; $display("FAIL rmid_data: got %h, required 00", data); end
        rstn = 1'b1;
        ticks(20);
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL rmid_quiet: got %b, required 0", valid); end
        ready = 1'b1;
        hs0 = hs_cnt;
        exp_q.push_back({8'h5A, 1'b0, 1'b0});
        send_frame(8'h5A, 1'b1);
        ticks(20);
        total++; if (hs_cnt - hs0 != 1) begin bad++; $display("FAIL rmid_next_hs: got %0d, required 1", hs_cnt - hs0); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_parity();
        test_reset_mid();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: got %0d pending words, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
